// File: rtl/reg_wr_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package reg_wr_arb_pkg;

  localparam int   NUM_REQ        = 2;
  localparam logic LAST_GRANT_RST = 1'b1;

  // The struct carries the widest fields any instance may use; narrower
  // instances zero-extend into it and slice back out.
  localparam int MAX_ADDR_W = 16;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer (last) lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Arbitrates the core writeback and debug/loader paths onto the single
// register-file write port, with one registered output stage.
module reg_wr_arbiter
  import reg_wr_arb_pkg::*;
#(
  parameter int ADDR_W = 5,   // must not exceed MAX_ADDR_W
  parameter int DATA_W = 32,  // must not exceed MAX_DATA_W
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              r3_wr,
  output logic [ADDR_W-1:0] r3_addr,
  output logic [DATA_W-1:0] r3_din,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              r0_drops,
  output logic [CNT_W-1:0]  contend_cnt
);

  wr_req_t              req_s [NUM_REQ];
  wr_req_t              win;
  logic [NUM_REQ-1:0]   gnt;
  logic                 xfer;
  logic                 sel;

  wr_req_t              out_q,        out_d;
  logic                 drop_q,       drop_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;

  always_comb begin
    req_s[0]       = '0;
    req_s[0].valid = req0_valid;
    req_s[0].addr  = MAX_ADDR_W'(req0_addr);
    req_s[0].data  = MAX_DATA_W'(req0_data);
    req_s[1]       = '0;
    req_s[1].valid = req1_valid;
    req_s[1].addr  = MAX_ADDR_W'(req1_addr);
    req_s[1].data  = MAX_DATA_W'(req1_data);
  end

  // Reset also gates the grant so no handshake completes while it is high.
  rr_arb2 u_rr_arb2 (
    .req  ({req1_valid, req0_valid}),
    .en   (!stall && !rst),
    .last (last_grant_q),
    .gnt  (gnt)
  );

  assign xfer       = |gnt;
  assign sel        = gnt[1];
  assign win        = req_s[sel];
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    out_d        = out_q;
    out_d.valid  = 1'b0;
    drop_d       = 1'b0;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    if (xfer) begin
      // A $0 target is accepted but lands as a non-write; addr/data still load.
      out_d        = win;
      out_d.valid  = (win.addr != '0);
      drop_d       = (win.addr == '0);
      last_grant_d = sel;
    end

    if (!stall && req0_valid && req1_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      drop_q       <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      drop_q       <= drop_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign r3_wr       = out_q.valid;
  assign r3_addr     = out_q.addr[ADDR_W-1:0];
  assign r3_din      = out_q.data[DATA_W-1:0];
  assign pend_valid  = out_q.valid;
  assign pend_addr   = out_q.addr[ADDR_W-1:0];
  assign r0_drops    = drop_q;
  assign contend_cnt = cnt_q;

  // Zero-extended upper struct bits are structurally constant; fold them here.
  logic unused_out_bits;
  assign unused_out_bits = ^out_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Randomized and directed bench for reg_wr_arbiter against a cycle-level
// behavioural model; a second instance with a 3-bit counter covers saturation.
module tb_reg_wr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst, stall;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  logic          rdy0, rdy1, wr, pv, drop;
  logic [AW-1:0] addr, pa;
  logic [DW-1:0] din;
  logic [CW-1:0] cnt;

  logic          s_rdy0, s_rdy1, s_wr, s_pv, s_drop;
  logic [AW-1:0] s_addr, s_pa;
  logic [DW-1:0] s_din;
  logic [SW-1:0] s_cnt;

  always #5 clk = ~clk;

  reg_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1),
    .r3_wr(wr), .r3_addr(addr), .r3_din(din),
    .pend_valid(pv), .pend_addr(pa), .r0_drops(drop), .contend_cnt(cnt)
  );

  reg_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(SW)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(s_rdy0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(s_rdy1),
    .r3_wr(s_wr), .r3_addr(s_addr), .r3_din(s_din),
    .pend_valid(s_pv), .pend_addr(s_pa), .r0_drops(s_drop), .contend_cnt(s_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the register-file port should show after each edge.
  int            m_last;
  logic          m_wr, m_drop;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  int            m_cnt;
  int            last_g;

  function automatic int sat(input int v, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_last = 1; m_wr = 1'b0; m_drop = 1'b0; m_addr = '0; m_din = '0; m_cnt = 0;
  endtask

  // One clock cycle: check at the falling edge, then advance the model at the rising edge.
  task automatic step();
    int g;
    @(negedge clk);
    g = -1;
    if (!rst && !stall) begin
      if (v0 && v1)  g = (m_last == 1) ? 0 : 1;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
    end
    check("ready0",   rdy0,   g == 0);
    check("ready1",   rdy1,   g == 1);
    check("r3_wr",    wr,     m_wr);
    check("r3_addr",  addr,   m_addr);
    check("r3_din",   din,    m_din);
    check("pend_v",   pv,     m_wr);
    check("pend_a",   pa,     m_addr);
    check("r0_drops", drop,   m_drop);
    check("cnt",      cnt,    sat(m_cnt, CW));
    check("s_ready0", s_rdy0, g == 0);
    check("s_ready1", s_rdy1, g == 1);
    check("s_r3_wr",  s_wr,   m_wr);
    check("s_r3_addr",s_addr, m_addr);
    check("s_r3_din", s_din,  m_din);
    check("s_pend_v", s_pv,   m_wr);
    check("s_pend_a", s_pa,   m_addr);
    check("s_drops",  s_drop, m_drop);
    check("s_cnt",    s_cnt,  sat(m_cnt, SW));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_addr = (g == 1) ? a1 : a0;
        m_din  = (g == 1) ? d1 : d0;
        m_wr   = (m_addr != 0);
        m_drop = (m_addr == 0);
        m_last = g;
      end else begin
        m_wr   = 1'b0;
        m_drop = 1'b0;
      end
      if (!stall && v0 && v1) m_cnt++;
    end
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  logic [AW-1:0] seq [4];
  logic [CW-1:0] cnt_hold;

  initial begin
    rst = 1'b1; stall = 1'b0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    model_reset();
    last_g = -1;
    @(posedge clk); #1;

    // Reset state
    check("rst_wr",   wr,   1'b0);
    check("rst_addr", addr, '0);
    check("rst_din",  din,  '0);
    check("rst_drop", drop, 1'b0);
    check("rst_cnt",  cnt,  '0);

    // Single writer: request in cycle 3, write visible in cycle 4
    rst = 1'b0;
    step(); step();
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEAD_BEEF;
    step();
    check("single_gnt",  last_g, 0);
    check("single_wr",   wr,   1'b1);
    check("single_addr", addr, 5'd5);
    check("single_din",  din,  32'hDEAD_BEEF);
    v0 = 1'b0;
    step();
    check("single_wr_off", wr, 1'b0);

    // Contention: grants alternate starting with requester 0
    do_reset();
    v0 = 1'b1; a0 = 5'd1; d0 = $urandom;
    v1 = 1'b1; a1 = 5'd2; d1 = $urandom;
    for (int i = 0; i < 4; i++) begin
      step();
      seq[i] = addr;
    end
    check("cont_a0", seq[0], 5'd1);
    check("cont_a1", seq[1], 5'd2);
    check("cont_a2", seq[2], 5'd1);
    check("cont_a3", seq[3], 5'd2);
    check("cont_cnt", cnt, 16'd4);

    // $0 suppression from requester 1
    v0 = 1'b0; v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
    step();
    check("r0_gnt",  last_g, 1);
    check("r0_wr",   wr,   1'b0);
    check("r0_drop", drop, 1'b1);
    check("r0_din",  din,  32'h1234);
    v1 = 1'b0;
    step();
    check("r0_drop_off", drop, 1'b0);

    // Stall: no grants, counter frozen; requester 0 wins on release
    cnt_hold = cnt;
    v0 = 1'b1; a0 = 5'd7; d0 = $urandom;
    v1 = 1'b1; a1 = 5'd9; d1 = $urandom;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("stall_cnt", cnt, cnt_hold);
    check("stall_wr",  wr,  1'b0);
    stall = 1'b0;
    step();
    check("unstall_addr", addr, 5'd7);
    v0 = 1'b0;

    // Reset mid-operation discards the registered write
    v1 = 1'b0; v0 = 1'b1; a0 = 5'd3; d0 = $urandom;
    step();
    rst = 1'b1; v0 = 1'b1; a0 = 5'd4; v1 = 1'b1; a1 = 5'd6;
    step();
    rst = 1'b0;
    check("mid_wr",   wr,   1'b0);
    check("mid_addr", addr, '0);
    check("mid_din",  din,  '0);
    check("mid_cnt",  cnt,  '0);
    step();
    check("mid_first", addr, 5'd4);

    // Saturation of the narrow counter
    do_reset();
    v0 = 1'b1; v1 = 1'b1; a0 = 5'd10; a1 = 5'd11;
    for (int i = 0; i < 10; i++) step();
    check("sat_cnt",  s_cnt, 3'd7);
    check("wide_cnt", cnt,   16'd10);
    v0 = 1'b0; v1 = 1'b0;

    // Randomized traffic with held requests, stalls and occasional resets
    for (int c = 0; c < 600; c++) begin
      if (last_g == 0) v0 = 1'b0;
      if (last_g == 1) v1 = 1'b0;
      if (!v0 && ($urandom_range(0, 2) != 0)) begin
        v0 = 1'b1;
        a0 = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
        d0 = $urandom;
      end
      if (!v1 && ($urandom_range(0, 2) != 0)) begin
        v1 = 1'b1;
        a1 = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
        d1 = $urandom;
      end
      stall = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
